// File: rtl/ddr2_fifo_chk_pkg.sv
// Shared state encoding and default widths for the DDR2 FIFO read-side checker.
package ddr2_fifo_chk_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF  = 32;
   localparam int WD_WIDTH       = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } chk_state_e;

endpackage

// File: rtl/ddr2_fifo_pattern_cmp.sv
// Incrementing-pattern comparator: tracks the expected word, counts words and
// mismatches, and captures the first mismatching pair.
module ddr2_fifo_pattern_cmp
   import ddr2_fifo_chk_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  rd_clk,
   input  logic                  reset_n,
   input  logic                  dout_vd,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  err_flag,
   output logic [DATA_WIDTH-1:0] first_err_exp,
   output logic [DATA_WIDTH-1:0] first_err_got
);

   logic [DATA_WIDTH-1:0] expected_q, expected_d;
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic                  err_flag_q, err_flag_d;
   logic [DATA_WIDTH-1:0] first_exp_q, first_exp_d;
   logic [DATA_WIDTH-1:0] first_got_q, first_got_d;
   logic                  mismatch;

   assign mismatch = (data_out != expected_q);

   always_comb begin
      expected_d  = expected_q;
      word_cnt_d  = word_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;
      if (dout_vd) begin
         // Follow the received stream so a single dropped word costs one error.
         expected_d = data_out + DATA_WIDTH'(1);
         if (word_cnt_q != '1) begin
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
         end
         if (mismatch) begin
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
            if (!err_flag_q) begin
               err_flag_d  = 1'b1;
               first_exp_d = expected_q;
               first_got_d = data_out;
            end
         end
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!reset_n) begin
         expected_q  <= '0;
         word_cnt_q  <= '0;
         err_cnt_q   <= '0;
         err_flag_q  <= 1'b0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else begin
         expected_q  <= expected_d;
         word_cnt_q  <= word_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
      end
   end

   assign word_cnt      = word_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign err_flag      = err_flag_q;
   assign first_err_exp = first_exp_q;
   assign first_err_got = first_got_q;

endmodule

// File: rtl/ddr2_fifo_rd_checker.sv
// Read-side consumer/checker for the DDR2-backed FIFO: bursts rd_en, tracks
// outstanding reads, and checks returned data. Optional watchdog: RDCHK_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | disabled; waits for phy_init_done & chk_en
// ST_WAIT  | enabled; waits for data in the FIFO and read credit
// ST_READ  | issuing a rd_en burst
// ST_DRAIN | burst closed; waits for all issued reads to return
module ddr2_fifo_rd_checker
   import ddr2_fifo_chk_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
   input  logic                  rd_clk,
   input  logic                  reset_n,
   input  logic                  phy_init_done,
   input  logic                  empty,
   input  logic                  almost_empty,
   input  logic                  dout_vd,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic                  chk_en,
   output logic                  rd_en,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  err_flag,
   output logic [DATA_WIDTH-1:0] first_err_exp,
   output logic [DATA_WIDTH-1:0] first_err_got,
`ifdef RDCHK_TIMEOUT_EN
   output logic                  timeout,
`endif
   output logic                  busy
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int BL_W  = $clog2(BURST_LEN + 1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
   localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(BURST_LEN);

   chk_state_e        state_q, state_d;
   logic [OUT_W-1:0]  outstanding_q, outstanding_d;
   logic [BL_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              rd_accept;
`ifdef RDCHK_TIMEOUT_EN
   logic [WD_WIDTH-1:0] wd_q, wd_d;
   logic                timeout_q, timeout_d;
   logic                wd_hit;

   assign wd_hit  = (wd_q == '1);
   assign timeout = timeout_q;
`endif

   // The registered request is masked by the live empty flag so a read is
   // never presented against an empty FIFO.
   assign rd_en     = rd_en_q & ~empty;
   assign rd_accept = rd_en;

   always_ff @(posedge rd_clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         outstanding_q <= '0;
         burst_cnt_q   <= '0;
         rd_en_q       <= 1'b0;
`ifdef RDCHK_TIMEOUT_EN
         wd_q          <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         burst_cnt_q   <= burst_cnt_d;
         rd_en_q       <= rd_en_d;
`ifdef RDCHK_TIMEOUT_EN
         wd_q          <= wd_d;
         timeout_q     <= timeout_d;
`endif
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (rd_accept && !dout_vd) begin
         outstanding_d = outstanding_q + OUT_W'(1);
      end else if (!rd_accept && dout_vd && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - OUT_W'(1);
      end

      burst_cnt_d = burst_cnt_q;
      if (state_q != ST_READ) begin
         burst_cnt_d = '0;
      end else if (rd_accept) begin
         burst_cnt_d = burst_cnt_q + BL_W'(1);
      end

`ifdef RDCHK_TIMEOUT_EN
      timeout_d = timeout_q | wd_hit;
      if (dout_vd || (outstanding_q == '0) || wd_hit) begin
         wd_d = '0;
      end else begin
         wd_d = wd_q + WD_WIDTH'(1);
      end
      // Give up on reads that will never return.
      if (wd_hit) begin
         outstanding_d = '0;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (phy_init_done && chk_en) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!empty && chk_en && (outstanding_q < OUT_MAX)) begin
               state_d = ST_READ;
            end else if (!chk_en && (outstanding_q == '0)) begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if ((burst_cnt_d >= BL_MAX) || empty || !chk_en ||
                (almost_empty && (burst_cnt_d != '0))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (outstanding_q == '0) state_d = ST_WAIT;
`ifdef RDCHK_TIMEOUT_EN
            if (wd_hit) state_d = ST_WAIT;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request for the next cycle uses next-cycle credit and burst count so the
   // limits hold even when a read is accepted this cycle.
   always_comb begin
      rd_en_d = (state_d == ST_READ) && !empty &&
                (outstanding_d < OUT_MAX) && (burst_cnt_d < BL_MAX);
      busy    = (state_q != ST_IDLE);
   end

   ddr2_fifo_pattern_cmp #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_pattern_cmp (
      .rd_clk        (rd_clk),
      .reset_n       (reset_n),
      .dout_vd       (dout_vd),
      .data_out      (data_out),
      .word_cnt      (word_cnt),
      .err_cnt       (err_cnt),
      .err_flag      (err_flag),
      .first_err_exp (first_err_exp),
      .first_err_got (first_err_got)
   );

endmodule

// File: tb/tb_ddr2_fifo_rd_checker.sv
// Self-checking bench for ddr2_fifo_rd_checker with a queue-based FIFO model and
// a stream-level reference checker. Define RDCHK_TIMEOUT_EN to cover the watchdog.
module tb_ddr2_fifo_rd_checker;

   localparam int DW      = 32;
   localparam int CW      = 32;
   localparam int MAXO    = 8;
   localparam int LAT_MAX = 12;

   logic          rd_clk = 1'b0;
   logic          reset_n, phy_init_done, empty, almost_empty, dout_vd, chk_en;
   logic [DW-1:0] data_out;
   logic          rd_en, err_flag, busy;
   logic [CW-1:0] word_cnt, err_cnt;
   logic [DW-1:0] first_err_exp, first_err_got;
`ifdef RDCHK_TIMEOUT_EN
   logic          timeout;
`endif

   always #5 rd_clk = ~rd_clk;

   ddr2_fifo_rd_checker #(
      .DATA_WIDTH      (DW),
      .BURST_LEN       (16),
      .MAX_OUTSTANDING (MAXO),
      .CNT_WIDTH       (CW)
   ) dut (
      .rd_clk        (rd_clk),
      .reset_n       (reset_n),
      .phy_init_done (phy_init_done),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .dout_vd       (dout_vd),
      .data_out      (data_out),
      .chk_en        (chk_en),
      .rd_en         (rd_en),
      .word_cnt      (word_cnt),
      .err_cnt       (err_cnt),
      .err_flag      (err_flag),
      .first_err_exp (first_err_exp),
      .first_err_got (first_err_got),
`ifdef RDCHK_TIMEOUT_EN
      .timeout       (timeout),
`endif
      .busy          (busy)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] fifo_q[$];
   logic [31:0] log_q[$];
   bit          pipe_v[LAT_MAX];
   logic [31:0] pipe_d[LAT_MAX];
   int          lat = 3;
   bit          toggle_mode = 0;
   bit          drop_mode = 0;
   bit          rst_cmd = 0;
   bit          chk_cmd = 0;
   bit          phy_cmd = 0;
   int          cyc = 0;
   int          viol = 0;
   int          max_out = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit pipe_busy();
      bit b = 0;
      foreach (pipe_v[i]) b |= pipe_v[i];
      return b;
   endfunction

   // One rd_clk cycle: drive inputs at negedge, observe the read request just
   // before the next posedge and move accepted words into the return pipe.
   task automatic step();
      logic [31:0] d;
      int occ;
      @(negedge rd_clk);
      reset_n       = rst_cmd;
      chk_en        = chk_cmd;
      phy_init_done = phy_cmd;
      dout_vd       = pipe_v[0];
      data_out      = pipe_v[0] ? pipe_d[0] : $urandom();
      for (int i = 0; i < LAT_MAX - 1; i++) begin
         pipe_v[i] = pipe_v[i+1];
         pipe_d[i] = pipe_d[i+1];
      end
      pipe_v[LAT_MAX-1] = 1'b0;
      if (!reset_n) log_q.delete();
      else if (dout_vd) log_q.push_back(data_out);
      cyc++;
      empty        = (fifo_q.size() == 0) || (toggle_mode && ((cyc % 6) < 3));
      almost_empty = (fifo_q.size() <= 2);
      #2;
      if (rd_en && empty) viol++;
      if (rd_en && !empty) begin
         d = fifo_q.pop_front();
         if (!drop_mode) begin
            pipe_v[lat-1] = 1'b1;
            pipe_d[lat-1] = d;
         end
      end
      occ = 0;
      foreach (pipe_v[i]) occ += int'(pipe_v[i]);
      if (occ > max_out) max_out = occ;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((fifo_q.size() != 0 || pipe_busy()) && n < budget) begin
         step();
         n++;
      end
      repeat (4) step();
      check({tag, "_drain_done"}, 32'(n < budget), 32'd1);
   endtask

   task automatic do_reset(input int n);
      rst_cmd = 0;
      repeat (n) step();
      rst_cmd = 1;
      step();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_word_cnt"}, word_cnt, 32'd0);
      check({tag, "_err_cnt"}, err_cnt, 32'd0);
      check({tag, "_err_flag"}, 32'(err_flag), 32'd0);
      check({tag, "_first_exp"}, first_err_exp, 32'd0);
      check({tag, "_first_got"}, first_err_got, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
   endtask

   // Reference: walk every word delivered since the last reset.
   task automatic check_model(input string tag);
      logic [31:0] e, fexp, fgot;
      int cnt, errs;
      bit flag;
      e = 0; fexp = 0; fgot = 0; cnt = 0; errs = 0; flag = 0;
      foreach (log_q[i]) begin
         if (log_q[i] != e) begin
            errs++;
            if (!flag) begin
               flag = 1;
               fexp = e;
               fgot = log_q[i];
            end
         end
         e = log_q[i] + 32'd1;
         cnt++;
      end
      check({tag, "_word_cnt"}, word_cnt, 32'(cnt));
      check({tag, "_err_cnt"}, err_cnt, 32'(errs));
      check({tag, "_err_flag"}, 32'(err_flag), 32'(flag));
      check({tag, "_first_exp"}, first_err_exp, fexp);
      check({tag, "_first_got"}, first_err_got, fgot);
   endtask

   initial begin
      reset_n = 0; phy_init_done = 0; chk_en = 0; empty = 1; almost_empty = 1;
      dout_vd = 0; data_out = '0;
      foreach (pipe_v[i]) begin
         pipe_v[i] = 0;
         pipe_d[i] = '0;
      end

      // Reset held 400 ns with the FIFO preloaded 0..149
      for (int i = 0; i < 150; i++) fifo_q.push_back(32'(i));
      phy_cmd = 1;
      chk_cmd = 1;
      do_reset(40);
      check_reset_state("rst");

      drain("seq150", 3000);
      check("seq150_word_cnt", word_cnt, 32'd150);
      check("seq150_err_cnt", err_cnt, 32'd0);
      check("seq150_err_flag", 32'(err_flag), 32'd0);
      check("seq150_rd_en", 32'(rd_en), 32'd0);
      check("seq150_busy_wait", 32'(busy), 32'd1);
      check_model("seq150_model");

      // Single dropped word (10 missing)
      do_reset(2);
      for (int i = 0; i < 20; i++) if (i != 10) fifo_q.push_back(32'(i));
      drain("gap", 1000);
      check("gap_word_cnt", word_cnt, 32'd19);
      check("gap_err_cnt", err_cnt, 32'd1);
      check("gap_err_flag", 32'(err_flag), 32'd1);
      check("gap_first_exp", first_err_exp, 32'd10);
      check("gap_first_got", first_err_got, 32'd11);

      // Wrap: the leading word resyncs from 0 (one error); the wrap adds none
      do_reset(2);
      fifo_q.push_back(32'hFFFF_FFFE);
      fifo_q.push_back(32'hFFFF_FFFF);
      fifo_q.push_back(32'h0000_0000);
      fifo_q.push_back(32'h0000_0001);
      drain("wrap", 500);
      check("wrap_word_cnt", word_cnt, 32'd4);
      check("wrap_err_cnt", err_cnt, 32'd1);
      check("wrap_first_got", first_err_got, 32'hFFFF_FFFE);
      check("wrap_first_exp", first_err_exp, 32'd0);

      // Randomized streams: slow returns, toggling empty, chk_en flicker
      for (int r = 0; r < 4; r++) begin
         logic [31:0] v;
         int n;
         lat = (r % 2 == 1) ? LAT_MAX : 3;
         toggle_mode = (r >= 2);
         do_reset(2);
         viol = 0;
         max_out = 0;
         n = $urandom_range(40, 90);
         v = 0;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) v = $urandom();
            fifo_q.push_back(v);
            v = v + 32'd1;
         end
         for (int i = 0; i < 60; i++) begin
            chk_cmd = ($urandom_range(0, 9) != 0);
            step();
         end
         chk_cmd = 1;
         drain($sformatf("rnd%0d", r), 4000);
         check_model($sformatf("rnd%0d", r));
         check($sformatf("rnd%0d_rd_en_while_empty", r), 32'(viol), 32'd0);
         check($sformatf("rnd%0d_outstanding_le_max", r), 32'(max_out <= MAXO), 32'd1);
      end
      toggle_mode = 0;
      lat = 3;

      // One-cycle reset in the middle of a burst
      do_reset(2);
      for (int i = 0; i < 60; i++) fifo_q.push_back(32'(i));
      begin
         int n = 0;
         while (log_q.size() < 5 && n < 200) begin
            step();
            n++;
         end
         check("midrst_words_seen", 32'(log_q.size() >= 5), 32'd1);
      end
      rst_cmd = 0;
      step();
      rst_cmd = 1;
      step();
      check_reset_state("midrst");
      drain("midrst", 2000);
      check_model("midrst_after");

`ifdef RDCHK_TIMEOUT_EN
      // One read accepted, never returned
      do_reset(2);
      check("to_reset", 32'(timeout), 32'd0);
      drop_mode = 1;
      fifo_q.push_back(32'd0);
      begin
         int n = 0;
         while (timeout !== 1'b1 && n < 70000) begin
            step();
            n++;
         end
         check("to_set", 32'(timeout), 32'd1);
         check("to_not_early", 32'(n >= 65530), 32'd1);
      end
      drop_mode = 0;
      chk_cmd = 0;
      repeat (3) step();
      check("to_back_to_idle", 32'(busy), 32'd0);
      check("to_sticky", 32'(timeout), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
